// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle control FSM: opcodes, state codes and
// the datapath select values driven by the controller.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  localparam logic [3:0] S_IF      = 4'd0;
  localparam logic [3:0] S_ID      = 4'd1;
  localparam logic [3:0] S_EX_R    = 4'd2;
  localparam logic [3:0] S_EX_I    = 4'd3;
  localparam logic [3:0] S_EX_ADDR = 4'd4;
  localparam logic [3:0] S_MEM_R   = 4'd5;
  localparam logic [3:0] S_MEM_W   = 4'd6;
  localparam logic [3:0] S_WB      = 4'd7;
  localparam logic [3:0] S_EX_BR   = 4'd8;
  localparam logic [3:0] S_EX_JALR = 4'd9;
  localparam logic [3:0] S_JUMP    = 4'd10;
  localparam logic [3:0] S_PC4     = 4'd11;
  localparam logic [3:0] S_HALT    = 4'd12;

  typedef enum logic [3:0] {
    ST_IF      = S_IF,
    ST_ID      = S_ID,
    ST_EX_R    = S_EX_R,
    ST_EX_I    = S_EX_I,
    ST_EX_ADDR = S_EX_ADDR,
    ST_MEM_R   = S_MEM_R,
    ST_MEM_W   = S_MEM_W,
    ST_WB      = S_WB,
    ST_EX_BR   = S_EX_BR,
    ST_EX_JALR = S_EX_JALR,
    ST_JUMP    = S_JUMP,
    ST_PC4     = S_PC4,
    ST_HALT    = S_HALT
  } state_t;

  localparam logic [1:0] ALU_ADD    = 2'd0;
  localparam logic [1:0] ALU_FUNCT  = 2'd1;
  localparam logic [1:0] ALU_BRANCH = 2'd2;

  localparam logic [1:0] SRC_B_REG  = 2'd0;
  localparam logic [1:0] SRC_B_FOUR = 2'd1;
  localparam logic [1:0] SRC_B_IMM  = 2'd2;

  localparam logic [1:0] WB_ALUOUT  = 2'd0;
  localparam logic [1:0] WB_MDR     = 2'd1;
  localparam logic [1:0] WB_ALU     = 2'd2;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: status inputs to the FSM and every
// enable/select it drives back into the datapath.
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic       bcond;
  logic       halt_cond;
  logic       mem_ready;
  logic       pc_update;
  logic       pc_source;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mdr_write;
  logic       reg_write;
  logic [1:0] wb_sel;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       inst_done;
  logic       is_halted;

  modport master (
    input  opcode, bcond, halt_cond, mem_ready,
    output pc_update, pc_source, i_or_d, mem_read, mem_write, ir_write,
           mdr_write, reg_write, wb_sel, alu_src_a, alu_src_b, alu_op,
           inst_done, is_halted
  );

  modport slave (
    output opcode, bcond, halt_cond, mem_ready,
    input  pc_update, pc_source, i_or_d, mem_read, mem_write, ir_write,
           mdr_write, reg_write, wb_sel, alu_src_a, alu_src_b, alu_op,
           inst_done, is_halted
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle core control FSM: sequences IF/ID/EX/MEM/WB one instruction at a
// time, waits on mem_ready and parks in HALT until reset.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter bit UNKNOWN_HALT = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  multicycle_ctrl_if.master  bus
);

  state_t state_reg, state_next;
  logic   is_load_reg, is_load_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IF;
      is_load_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      is_load_reg <= is_load_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    is_load_next = is_load_reg;
    case (state_reg)
      ST_IF:      if (bus.mem_ready) state_next = ST_ID;
      ST_ID: begin
        is_load_next = 1'b0;
        case (bus.opcode)
          OP_R:               state_next = ST_EX_R;
          OP_I:               state_next = ST_EX_I;
          OP_LOAD, OP_STORE:  state_next = ST_EX_ADDR;
          OP_BRANCH:          state_next = ST_EX_BR;
          OP_JAL:             state_next = ST_JUMP;
          OP_JALR:            state_next = ST_EX_JALR;
          OP_ECALL:           state_next = bus.halt_cond ? ST_HALT : ST_PC4;
          default:            state_next = UNKNOWN_HALT ? ST_HALT : ST_PC4;
        endcase
      end
      ST_EX_R:    state_next = ST_WB;
      ST_EX_I:    state_next = ST_WB;
      ST_EX_ADDR: begin
        // The load flag later chooses MDR vs ALUOut for writeback.
        is_load_next = (bus.opcode == OP_LOAD);
        state_next   = (bus.opcode == OP_LOAD) ? ST_MEM_R : ST_MEM_W;
      end
      ST_MEM_R:   if (bus.mem_ready) state_next = ST_WB;
      ST_MEM_W:   if (bus.mem_ready) state_next = ST_IF;
      ST_WB:      state_next = ST_IF;
      ST_EX_BR:   state_next = bus.bcond ? ST_IF : ST_PC4;
      ST_EX_JALR: state_next = ST_JUMP;
      ST_JUMP:    state_next = ST_IF;
      ST_PC4:     state_next = ST_IF;
      ST_HALT:    state_next = ST_HALT;
      default:    state_next = ST_IF;
    endcase
  end

  logic       pc_write, pc_write_cond;
  logic       pc_source, i_or_d, mem_read, mem_write, ir_write, mdr_write;
  logic       reg_write, alu_src_a, inst_done, is_halted;
  logic [1:0] wb_sel, alu_src_b, alu_op;
  logic       pc_update;

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mdr_write     = 1'b0;
    reg_write     = 1'b0;
    wb_sel        = WB_ALUOUT;
    alu_src_a     = 1'b0;
    alu_src_b     = SRC_B_REG;
    alu_op        = ALU_ADD;
    inst_done     = 1'b0;
    is_halted     = 1'b0;
    case (state_reg)
      ST_IF: begin
        mem_read = 1'b1;
        ir_write = bus.mem_ready;
      end
      ST_ID: alu_src_b = SRC_B_IMM;
      ST_EX_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      ST_EX_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_FUNCT;
      end
      ST_EX_ADDR, ST_EX_JALR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
      end
      ST_MEM_R: begin
        mem_read  = 1'b1;
        i_or_d    = 1'b1;
        mdr_write = bus.mem_ready;
      end
      ST_MEM_W: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        alu_src_b = SRC_B_FOUR;
        pc_write  = bus.mem_ready;
        inst_done = bus.mem_ready;
      end
      ST_WB: begin
        reg_write = 1'b1;
        wb_sel    = is_load_reg ? WB_MDR : WB_ALUOUT;
        alu_src_b = SRC_B_FOUR;
        pc_write  = 1'b1;
        inst_done = 1'b1;
      end
      ST_EX_BR: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_BRANCH;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
        inst_done     = bus.bcond;
      end
      ST_JUMP: begin
        alu_src_b = SRC_B_FOUR;
        reg_write = 1'b1;
        wb_sel    = WB_ALU;
        pc_write  = 1'b1;
        pc_source = 1'b1;
        inst_done = 1'b1;
      end
      ST_PC4: begin
        alu_src_b = SRC_B_FOUR;
        pc_write  = 1'b1;
        inst_done = 1'b1;
      end
      ST_HALT: is_halted = 1'b1;
      default: ;
    endcase

    pc_update = pc_write | (pc_write_cond & bus.bcond);

    // Reset kills the in-flight instruction immediately, not a cycle later.
    if (reset) begin
      pc_update = 1'b0;
      pc_source = 1'b0;
      i_or_d    = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      mdr_write = 1'b0;
      reg_write = 1'b0;
      wb_sel    = WB_ALUOUT;
      alu_src_a = 1'b0;
      alu_src_b = SRC_B_REG;
      alu_op    = ALU_ADD;
      inst_done = 1'b0;
      is_halted = 1'b0;
    end
  end

  assign bus.pc_update = pc_update;
  assign bus.pc_source = pc_source;
  assign bus.i_or_d    = i_or_d;
  assign bus.mem_read  = mem_read;
  assign bus.mem_write = mem_write;
  assign bus.ir_write  = ir_write;
  assign bus.mdr_write = mdr_write;
  assign bus.reg_write = reg_write;
  assign bus.wb_sel    = wb_sel;
  assign bus.alu_src_a = alu_src_a;
  assign bus.alu_src_b = alu_src_b;
  assign bus.alu_op    = alu_op;
  assign bus.inst_done = inst_done;
  assign bus.is_halted = is_halted;

endmodule
